pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Parametrised fetch PC generator; successor to the single-width PC register. Drives the fetch
//  address and fetch enable to instruction memory. Adds a configurable reset vector and a
//  priority redirect path: exception flush over branch over sequential increment. A one-entry
//  pending-redirect latch holds a redirect that arrives while fetch is stalled, so it is not lost.
// PARAMETERS
//  PC_W         32            PC width in bits (>=8)
//  RESET_VECTOR 32'hBFC00000  first fetch address after reset (PC_W bits)
//  INC          4             sequential increment in bytes (power of two)
//  STALL_W      6             stall vector width; bit 0 = PC stage
//  LATCH_BRANCH 1             1: branch during stall is latched; 0: branch during stall dropped
// PORTS
//  clk                     in   1        clock
//  rst                     in   1        synchronous, active-high reset
//  stall                   in   STALL_W  pipeline stall vector; only stall[0] is used
//  flush                   in   1        exception/eret redirect request
//  new_pc                  in   PC_W     flush target
//  branch_flag_i           in   1        ID-stage taken-branch request
//  branch_target_address_i in   PC_W     branch target
//  pc                      out  PC_W     current fetch address (register)
//  ce                      out  1        fetch enable (register)
//  pc_misalign_o           out  1        registered; pc[log2(INC)-1:0] != 0
//  redirect_pending_o      out  1        pending-redirect latch is valid
// BEHAVIOUR
//  - Reset: ce=0, pc=RESET_VECTOR, pc_misalign_o=0, pending cleared. rst mid-operation discards
//    any pending redirect in the same edge.
//  - Cycle after rst falls: ce<=1, pc stays RESET_VECTOR. That is the first fetch.
//  - While ce=0, pc is forced to RESET_VECTOR.
//  - Next-pc priority at each edge with ce=1:
//    1. flush: pc<=new_pc, regardless of stall[0]; clears pending; ignores branch this cycle.
//    2. stall[0]=1: pc holds. A branch with LATCH_BRANCH=1 is written into pending
//       (a newer branch overwrites an older pending one).
//    3. stall[0]=0 and branch_flag_i: pc<=branch_target_address_i; clears pending. The live
//       branch is newer and wins over pending.
//    4. stall[0]=0 and pending valid: pc<=pending target; clear pending.
//    5. Otherwise: pc<=pc+INC, modulo 2^PC_W (wraps to 0, no flag).
//  - Pending latch is a 2-state FSM: EMPTY -> FULL on a captured branch; FULL -> EMPTY on
//    flush, rst, or consumption (rules 3/4). redirect_pending_o = (state==FULL).
//  - Latency: a redirect presented at edge N is on pc after edge N. A latched redirect appears
//    one edge after stall[0] falls.
//  - pc_misalign_o is updated with pc and never blocks the redirect; the exception unit acts on it.
//  - Targets are used at full PC_W width. There is no truncation or sign extension.
// STRUCTURE
//  - Shared defines/package: RESET_VECTOR default, STALL_PC index (0), PC_W default, INC default.
//  - One sub-module: pc_redirect_latch. It holds the valid flag, target register, and
//    capture/consume/clear controls.
//  - pc_gen holds the ce register, the priority mux, and the incrementer.
// TESTING
//  - Reset release: rst 1->0 -> ce=0,pc=BFC00000 in reset; then ce=1,pc=BFC00000; next BFC00004.
//  - Sequential: 4 unstalled cycles from 0x100 -> pc 0x104,0x108,0x10C,0x110.
//  - Wrap: pc=FFFFFFFC, no stall -> pc=00000000, pc_misalign_o=0.
//  - Branch in stall: stall[0]=1 2 cycles, branch to 0x2000 in the 1st -> pc held,
//    redirect_pending_o=1; on release pc=0x2000, pending=0. With LATCH_BRANCH=0 -> pc=held+4.
//  - Priority: stall[0]=1, branch 0x2000 and flush new_pc=0x380 in the same cycle -> pc=0x380
//    on that edge, pending=0. Branch alone on the release cycle with pending 0x2000 and live
//    0x3000 -> pc=0x3000.
//  - Misalign + reset mid-op: branch to 0x2002 -> pc=0x2002, pc_misalign_o=1. Pending valid then
//    rst pulse -> pending=0, ce=0, pc=BFC00000.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch PC generator: default widths, reset vector,
// stall-vector index of the PC stage and the pending-redirect state encoding.
package pc_gen_pkg;

   localparam int          PC_W_DEF         = 32;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
   localparam int          INC_DEF          = 4;
   localparam int          STALL_W_DEF      = 6;
   localparam int          STALL_PC         = 0;

   localparam logic [0:0]  PEND_EMPTY = 1'b0;
   localparam logic [0:0]  PEND_FULL  = 1'b1;

endpackage

// File: rtl/pc_gen_redirect_latch.sv
// One-entry pending-redirect latch: remembers a branch target seen while the
// PC stage is stalled until it is consumed, flushed or reset.
module pc_redirect_latch
   import pc_gen_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            capture,
   input  logic            clear,
   input  logic [PC_W-1:0] target_in,
   output logic            valid,
   output logic [PC_W-1:0] target
);

   logic [0:0] state;

   // Clear wins over capture; the top never asserts both, but a flush must never be lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= PEND_EMPTY;
      end else if (clear) begin
         state <= PEND_EMPTY;
      end else if (capture) begin
         state <= PEND_FULL;
      end
   end

   always_ff @(posedge clk) begin
      if (capture && !clear) begin
         target <= target_in;
      end
   end

   assign valid = (state == PEND_FULL);

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: reset vector, flush > branch > pending > increment
// priority, with a pending latch so redirects during a PC-stage stall survive.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              PC_W         = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(RESET_VECTOR_DEF),
   parameter int              INC          = INC_DEF,
   parameter int              STALL_W      = STALL_W_DEF,
   parameter bit              LATCH_BRANCH = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic [PC_W-1:0]    new_pc,
   input  logic               branch_flag_i,
   input  logic [PC_W-1:0]    branch_target_address_i,
   output logic [PC_W-1:0]    pc,
   output logic               ce,
   output logic               pc_misalign_o,
   output logic               redirect_pending_o
);

   localparam logic [PC_W-1:0] INC_V    = PC_W'(INC);
   localparam logic [PC_W-1:0] INC_MASK = PC_W'(INC - 1);

   logic            stall_pc;
   logic            unused_stall;
   logic            pend_valid;
   logic [PC_W-1:0] pend_target;
   logic            pend_capture;
   logic            pend_clear;
   logic [PC_W-1:0] pc_next;

   assign stall_pc     = stall[STALL_PC];
   assign unused_stall = ^stall;

   // Only a branch that cannot be taken now (stalled, not overridden by flush) is parked.
   assign pend_capture = LATCH_BRANCH && ce && !flush && stall_pc && branch_flag_i;
   assign pend_clear   = ce && (flush || (!stall_pc && (branch_flag_i || pend_valid)));

   pc_redirect_latch #(
      .PC_W (PC_W)
   ) u_latch (
      .clk       (clk),
      .rst       (rst),
      .capture   (pend_capture),
      .clear     (pend_clear),
      .target_in (branch_target_address_i),
      .valid     (pend_valid),
      .target    (pend_target)
   );

   always_comb begin
      pc_next = pc + INC_V;
      if (!ce) begin
         pc_next = RESET_VECTOR;
      end else if (flush) begin
         pc_next = new_pc;
      end else if (stall_pc) begin
         pc_next = pc;
      end else if (branch_flag_i) begin
         pc_next = branch_target_address_i;
      end else if (pend_valid) begin
         pc_next = pend_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ce            <= 1'b0;
         pc            <= RESET_VECTOR;
         pc_misalign_o <= 1'b0;
      end else begin
         ce            <= 1'b1;
         pc            <= pc_next;
         pc_misalign_o <= |(pc_next & INC_MASK);
      end
   end

   assign redirect_pending_o = pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: stimulus queues the expected post-edge state,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_pc_gen;

   typedef struct {
      logic [31:0] pc;
      logic        ce;
      logic        mis;
      logic        pend;
      logic        chk0;
      logic [31:0] pc0;
      int          idx;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        branch_flag_i;
   logic [31:0] branch_target_address_i;

   logic [31:0] pc,  pc0;
   logic        ce,  ce0;
   logic        mis, mis0;
   logic        pend, pend0;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   vec      = 0;

   always #5 clk = ~clk;

   pc_gen dut (
      .clk                     (clk),
      .rst                     (rst),
      .stall                   (stall),
      .flush                   (flush),
      .new_pc                  (new_pc),
      .branch_flag_i           (branch_flag_i),
      .branch_target_address_i (branch_target_address_i),
      .pc                      (pc),
      .ce                      (ce),
      .pc_misalign_o           (mis),
      .redirect_pending_o      (pend)
   );

   pc_gen #(.LATCH_BRANCH(1'b0)) dut0 (
      .clk                     (clk),
      .rst                     (rst),
      .stall                   (stall),
      .flush                   (flush),
      .new_pc                  (new_pc),
      .branch_flag_i           (branch_flag_i),
      .branch_target_address_i (branch_target_address_i),
      .pc                      (pc0),
      .ce                      (ce0),
      .pc_misalign_o           (mis0),
      .redirect_pending_o      (pend0)
   );

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
      end
   endtask

   // Monitor: every negedge with an outstanding expectation is a DUT output sample.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("pc",   e.idx, pc,          e.pc);
         chk("ce",   e.idx, 32'(ce),     32'(e.ce));
         chk("mis",  e.idx, 32'(mis),    32'(e.mis));
         chk("pend", e.idx, 32'(pend),   32'(e.pend));
         if (e.chk0) begin
            chk("pc_nolatch",   e.idx, pc0,         e.pc0);
            chk("pend_nolatch", e.idx, 32'(pend0),  32'h0);
         end
      end
   end

   task automatic step(input logic r, input logic st, input logic fl, input logic [31:0] npc,
                       input logic br, input logic [31:0] bta,
                       input logic [31:0] epc, input logic ece, input logic emis, input logic epend,
                       input logic c0, input logic [31:0] epc0);
      exp_t e;
      rst = r; stall = {5'b0, st}; flush = fl; new_pc = npc;
      branch_flag_i = br; branch_target_address_i = bta;
      @(posedge clk);
      vec++;
      e.pc = epc; e.ce = ece; e.mis = emis; e.pend = epend; e.chk0 = c0; e.pc0 = epc0; e.idx = vec;
      q.push_back(e);
      #1;
   endtask

   initial begin
      // reset and release
      step(1,0,0,0,0,0,              32'hBFC00000,0,0,0, 1,32'hBFC00000);
      step(0,0,0,0,0,0,              32'hBFC00000,1,0,0, 1,32'hBFC00000);
      step(0,0,0,0,0,0,              32'hBFC00004,1,0,0, 0,0);
      // sequential from 0x100
      step(0,0,0,0,1,32'h100,        32'h100,1,0,0, 0,0);
      step(0,0,0,0,0,0,              32'h104,1,0,0, 0,0);
      step(0,0,0,0,0,0,              32'h108,1,0,0, 0,0);
      step(0,0,0,0,0,0,              32'h10C,1,0,0, 0,0);
      step(0,0,0,0,0,0,              32'h110,1,0,0, 0,0);
      // wrap
      step(0,0,0,0,1,32'hFFFFFFFC,   32'hFFFFFFFC,1,0,0, 0,0);
      step(0,0,0,0,0,0,              32'h0,1,0,0, 0,0);
      step(0,0,0,0,0,0,              32'h4,1,0,0, 1,32'h4);
      // branch during stall: latched vs dropped
      step(0,1,0,0,1,32'h2000,       32'h4,1,0,1, 1,32'h4);
      step(0,1,0,0,0,0,              32'h4,1,0,1, 1,32'h4);
      step(0,0,0,0,0,0,              32'h2000,1,0,0, 1,32'h8);
      // flush beats stalled branch, resyncs both instances
      step(0,1,1,32'h380,1,32'h2000, 32'h380,1,0,0, 1,32'h380);
      // live branch beats pending
      step(0,1,0,0,1,32'h2000,       32'h380,1,0,1, 1,32'h380);
      step(0,0,0,0,1,32'h3000,       32'h3000,1,0,0, 1,32'h3000);
      // misalignment
      step(0,0,0,0,1,32'h2002,       32'h2002,1,1,0, 0,0);
      step(0,0,0,0,0,0,              32'h2006,1,1,0, 0,0);
      step(0,0,0,0,1,32'h2000,       32'h2000,1,0,0, 0,0);
      // pending discarded by reset
      step(0,1,0,0,1,32'h4000,       32'h2000,1,0,1, 0,0);
      step(1,0,0,0,0,0,              32'hBFC00000,0,0,0, 1,32'hBFC00000);
      step(0,0,0,0,0,0,              32'hBFC00000,1,0,0, 1,32'hBFC00000);
      step(0,0,0,0,0,0,              32'hBFC00004,1,0,0, 1,32'hBFC00004);
      // newer stalled branch overwrites older pending
      step(0,1,0,0,1,32'h5000,       32'hBFC00004,1,0,1, 0,0);
      step(0,1,0,0,1,32'h6000,       32'hBFC00004,1,0,1, 0,0);
      step(0,0,0,0,0,0,              32'h6000,1,0,0, 0,0);
      step(0,0,0,0,0,0,              32'h6004,1,0,0, 0,0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain pending=%0d expected=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
